// File: rtl/seg4_pkg.sv
// Shared constants for the 4-digit seven-segment display path: glyph codes,
// digit-select codes and small helpers for decoding the select bus.
package seg4_pkg;

    // Active-low glyph codes, bit 7 = dp (kept high / off for every digit)
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low digit selects; digit 1 is the least significant
    localparam logic [3:0] BIT_D1   = 4'b1110;
    localparam logic [3:0] BIT_D2   = 4'b1101;
    localparam logic [3:0] BIT_D3   = 4'b1011;
    localparam logic [3:0] BIT_D4   = 4'b0111;
    localparam logic [3:0] BIT_NONE = 4'b1111;

    typedef enum logic {
        ST_HELD,
        ST_SETTLE
    } scan_state_t;

    // True when exactly one select line is driven low
    function automatic logic is_single_slot(input logic [3:0] sel);
        return (sel == BIT_D1) || (sel == BIT_D2) || (sel == BIT_D3) || (sel == BIT_D4);
    endfunction

    // Slot index of a single-low select; only meaningful when is_single_slot()
    function automatic logic [1:0] slot_index(input logic [3:0] sel);
        case (sel)
            BIT_D2:  return 2'd1;
            BIT_D3:  return 2'd2;
            BIT_D4:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph-to-BCD decoder. Only the ten exact digit codes are
// valid; anything else, including a lit decimal point, is flagged invalid.
module seg7_decode
    import seg4_pkg::*;
(
    input  logic [7:0] sm_seg,
    output logic       valid,
    output logic [3:0] bcd
);

    // Exact-match lookup from active-low glyph to BCD value
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        valid = 1'b1;
        bcd   = 4'd0;
        case (sm_seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg4_scan_decoder.sv
// Receive side of the multiplexed 4-digit display: synchronizes the segment
// and select buses, waits for each slot to settle, decodes the glyph and
// assembles the four digits into a frame.
module seg4_scan_decoder
    import seg4_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic        clk_24m,
    input  logic        rst_n,
    input  logic [7:0]  sm_seg,
    input  logic [3:0]  sm_bit,
    output logic [15:0] digits,
    output logic        frame_valid,
    output logic [3:0]  digit_mask,
    output logic        pattern_err
);

    localparam logic [15:0] STABLE_LIMIT = 16'(STABLE_CYCLES);

    logic [11:0]      sync1, sync2;
    logic [3:0]       s_bit;
    logic [7:0]       s_seg;
    logic             changing;

    scan_state_t      state, state_next;
    logic [15:0]      count, count_next;
    logic             accept;

    logic             seg_valid;
    logic [3:0]       seg_bcd;
    logic             is_blank, is_slot;
    logic [1:0]       idx;
    logic             capture, error;
    logic [3:0]       mask_merged;
    logic [3:0][3:0]  shadow, shadow_merged;

    assign s_bit = sync2[11:8];
    assign s_seg = sync2[7:0];
    // The next sample differs from the current one: s changes at the next edge,
    // so the counter can be loaded with 1 for the first cycle of the new value.
    assign changing = (sync1 != sync2);

    // Two-flop synchronizer; resets to the blank pattern
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 12'hFFF;
            sync2 <= 12'hFFF;
        end else begin
            // NOTE: non-blocking assignments so sync2 takes the old sync1, forming a real two-stage chain.
            sync1 <= {sm_bit, sm_seg};
            sync2 <= sync1;
        end
    end

    // Stability FSM state and run-length counter
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HELD;
            count <= 16'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next state: accept once the sample has held long enough, restart on change
    always_comb begin
        state_next = state;
        count_next = (count == 16'hFFFF) ? count : count + 16'd1;
        accept     = (state == ST_SETTLE) && (count == STABLE_LIMIT);
        if (accept) begin
            state_next = ST_HELD;
        end
        if (changing) begin
            state_next = ST_SETTLE;
            count_next = 16'd1;
        end
    end

    seg7_decode u_decode (
        .sm_seg (s_seg),
        .valid  (seg_valid),
        .bcd    (seg_bcd)
    );

    // Classify the accepted sample and pre-compute the merged frame state
    always_comb begin
        is_blank      = (s_bit == BIT_NONE);
        is_slot       = is_single_slot(s_bit);
        idx           = slot_index(s_bit);
        capture       = accept && is_slot && seg_valid;
        error         = accept && !is_blank && !(is_slot && seg_valid);
        mask_merged   = digit_mask | (4'b0001 << idx);
        shadow_merged = shadow;
        shadow_merged[idx] = seg_bcd;
    end

    // Frame assembly: shadow capture, mask tracking, frame publish or discard
    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow is only 16 flops, so it is reset along with everything else.
            shadow      <= '0;
            digit_mask  <= 4'h0;
            digits      <= 16'h0000;
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            pattern_err <= 1'b0;
            if (error) begin
                pattern_err <= 1'b1;
                digit_mask  <= 4'h0;
            end else if (capture) begin
                shadow <= shadow_merged;
                if (mask_merged == 4'hF) begin
                    digits      <= shadow_merged;
                    frame_valid <= 1'b1;
                    digit_mask  <= 4'h0;
                end else begin
                    digit_mask <= mask_merged;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg4_scan_decoder.sv
// Directed self-checking bench for seg4_scan_decoder.
module tb_seg4_scan_decoder;
    import seg4_pkg::*;

    logic        clk_24m = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  sm_seg  = SEG_BLANK;
    logic [3:0]  sm_bit  = BIT_NONE;
    logic [15:0] digits;
    logic        frame_valid;
    logic [3:0]  digit_mask;
    logic        pattern_err;

    int checks_total  = 0;
    int checks_passed = 0;
    int fv_cnt   = 0;
    int pe_cnt   = 0;
    int both_cnt = 0;

    seg4_scan_decoder #(.STABLE_CYCLES(16)) dut (
        .clk_24m     (clk_24m),
        .rst_n       (rst_n),
        .sm_seg      (sm_seg),
        .sm_bit      (sm_bit),
        .digits      (digits),
        .frame_valid (frame_valid),
        .digit_mask  (digit_mask),
        .pattern_err (pattern_err)
    );

    always #21 clk_24m = ~clk_24m;

    // Count output pulses, sampled away from the active edge
    always @(negedge clk_24m) begin
        if (frame_valid) fv_cnt++;
        if (pattern_err) pe_cnt++;
        if (frame_valid && pattern_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Present one slot and hold it for n cycles; returns at a falling edge
    task automatic slot(input logic [3:0] b, input logic [7:0] s, input int n);
        sm_bit = b;
        sm_seg = s;
        repeat (n) @(negedge clk_24m);
    endtask

    int fv0, pe0;

    initial begin
        repeat (3) @(negedge clk_24m);
        check("reset_digits", digits, 16'h0000);
        check("reset_fv", frame_valid, 0);
        check("reset_mask", digit_mask, 0);
        check("reset_pe", pattern_err, 0);
        rst_n = 1'b1;

        // Constant blank after reset: nothing happens
        repeat (100) @(negedge clk_24m);
        check("idle_fv", fv_cnt, 0);
        check("idle_pe", pe_cnt, 0);
        check("idle_mask", digit_mask, 0);

        // Normal frame 4321
        slot(BIT_D1, SEG_1, 64); check("nf_mask1", digit_mask, 4'b0001);
        slot(BIT_D2, SEG_2, 64); check("nf_mask2", digit_mask, 4'b0011);
        slot(BIT_D3, SEG_3, 64); check("nf_mask3", digit_mask, 4'b0111);
        check("nf_no_early_fv", fv_cnt, 0);
        slot(BIT_D4, SEG_4, 64); check("nf_mask4", digit_mask, 4'b0000);
        check("nf_fv", fv_cnt, 1);
        check("nf_digits", digits, 16'h4321);

        // Glitch rejection on slot 1
        slot(BIT_D1, SEG_1, 64);
        check("gl_mask_before", digit_mask, 4'b0001);
        for (int i = 0; i < 10; i++) begin
            sm_seg = (i % 2 == 0) ? SEG_2 : SEG_6;
            @(negedge clk_24m);
        end
        slot(BIT_D1, SEG_1, 64);
        check("gl_mask_after", digit_mask, 4'b0001);
        check("gl_no_pe", pe_cnt, 0);
        slot(BIT_D2, SEG_5, 64);
        slot(BIT_D3, SEG_6, 64);
        slot(BIT_D4, SEG_7, 64);
        check("gl_fv", fv_cnt, 2);
        check("gl_digits", digits, 16'h7651);

        // Illegal glyph: 1234 frame then a blank glyph in slot 1
        slot(BIT_D1, SEG_4, 64);
        slot(BIT_D2, SEG_3, 64);
        slot(BIT_D3, SEG_2, 64);
        slot(BIT_D4, SEG_1, 64);
        check("ig_digits", digits, 16'h1234);
        fv0 = fv_cnt;
        slot(BIT_D1, SEG_BLANK, 64);
        check("ig_pe", pe_cnt, 1);
        check("ig_mask_cleared", digit_mask, 0);
        slot(BIT_D2, SEG_5, 64);
        slot(BIT_D3, SEG_6, 64);
        slot(BIT_D4, SEG_7, 64);
        check("ig_no_fv", fv_cnt, fv0);
        check("ig_digits_kept", digits, 16'h1234);
        check("ig_mask3", digit_mask, 4'b1110);
        slot(BIT_D1, SEG_8, 64);
        check("ig_fv", fv_cnt, fv0 + 1);
        check("ig_digits_new", digits, 16'h7658);
        check("ig_pe_once", pe_cnt, 1);

        // Illegal select
        slot(BIT_D1, SEG_0, 64);
        check("is_mask_pre", digit_mask, 4'b0001);
        slot(4'b1100, SEG_0, 32);
        check("is_pe", pe_cnt, 2);
        check("is_mask", digit_mask, 0);
        slot(BIT_NONE, SEG_BLANK, 32);
        check("is_blank_no_pe", pe_cnt, 2);
        check("is_blank_mask", digit_mask, 0);

        // Overwrite slot 1
        fv0 = fv_cnt;
        slot(BIT_D1, SEG_0, 64);
        slot(BIT_D1, SEG_8, 64);
        check("ow_mask", digit_mask, 4'b0001);
        slot(BIT_D2, SEG_9, 64);
        slot(BIT_D3, SEG_9, 64);
        slot(BIT_D4, SEG_9, 64);
        check("ow_fv", fv_cnt, fv0 + 1);
        check("ow_digits", digits, 16'h9998);

        // Reset mid-frame
        slot(BIT_D1, SEG_1, 64);
        slot(BIT_D2, SEG_2, 64);
        check("rm_mask_pre", digit_mask, 4'b0011);
        sm_bit = BIT_NONE;
        sm_seg = SEG_BLANK;
        rst_n  = 1'b0;
        #1;
        check("rm_digits", digits, 16'h0000);
        check("rm_mask", digit_mask, 0);
        check("rm_fv_lvl", frame_valid, 0);
        check("rm_pe_lvl", pattern_err, 0);
        @(negedge clk_24m);
        rst_n = 1'b1;
        fv0 = fv_cnt;
        pe0 = pe_cnt;
        slot(BIT_D3, SEG_3, 64);
        slot(BIT_D4, SEG_4, 64);
        check("rm_no_fv", fv_cnt, fv0);
        check("rm_no_pe", pe_cnt, pe0);
        check("rm_mask_after", digit_mask, 4'b1100);
        check("rm_digits_after", digits, 16'h0000);

        check("never_fv_and_pe", both_cnt, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
